// File: rtl/disp_vramctrl_pkg.sv
// Shared constants and helpers for the display VRAM read controller.
package disp_pkg;

    localparam int unsigned AXI_ADDR_W      = 32;
    localparam int unsigned AXI_DATA_W      = 32;
    localparam int unsigned AXI_LEN_W       = 8;
    localparam int unsigned BYTES_PER_PIXEL = 4;
    localparam int unsigned BASE_W          = 29;
    localparam int unsigned BASE_LSB        = 6;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE     = 2'd0;
    localparam state_t S_WAIT_BUF = 2'd1;
    localparam state_t S_ADDR     = 2'd2;
    localparam state_t S_DATA     = 2'd3;

    function automatic int unsigned frame_bursts(input int unsigned h_pixels,
                                                 input int unsigned v_lines,
                                                 input int unsigned burst_len);
        return (h_pixels * v_lines) / burst_len;
    endfunction

endpackage

// File: rtl/disp_vramctrl_if.sv
// AXI4 read channel plus display line-buffer write port seen by the VRAM controller.
interface disp_vramctrl_if;
    import disp_pkg::*;

    logic [AXI_ADDR_W-1:0] ARADDR;
    logic [AXI_LEN_W-1:0]  ARLEN;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [AXI_DATA_W-1:0] RDATA;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;
    logic [AXI_DATA_W-1:0] BUF_WDATA;
    logic                  BUF_WREN;
    logic                  BUF_WREADY;

    modport master (
        output ARADDR, ARLEN, ARVALID, RREADY, BUF_WDATA, BUF_WREN,
        input  ARREADY, RDATA, RLAST, RVALID, BUF_WREADY
    );

    modport slave (
        input  ARADDR, ARLEN, ARVALID, RREADY, BUF_WDATA, BUF_WREN,
        output ARREADY, RDATA, RLAST, RVALID, BUF_WREADY
    );

endinterface

// File: rtl/disp_vramctrl.sv
// Display VRAM read controller: one frame of AXI read bursts per VSYNC falling edge,
// pixel words forwarded to the line buffer one cycle after each accepted beat.
module disp_vramctrl
    import disp_pkg::*;
#(
    parameter int unsigned H_PIXELS  = 640,
    parameter int unsigned V_LINES   = 480,
    parameter int unsigned BURST_LEN = 16
) (
    input  logic              ACLK,
    input  logic              ARST_X,
    input  logic              DSP_VSYNC_X,
    input  logic              DISPON,
    input  logic [BASE_W-1:0] DISPADDR,
    disp_vramctrl_if.master   vram
);

    localparam int unsigned FRAME_BURSTS = frame_bursts(H_PIXELS, V_LINES, BURST_LEN);
    localparam logic [AXI_ADDR_W-1:0] BURST_BYTES =
        AXI_ADDR_W'(BURST_LEN * BYTES_PER_PIXEL);
    localparam logic [31:0] LAST_BURST = 32'(FRAME_BURSTS - 1);

    state_t                   r_state;
    state_t                   w_state_d;
    logic                     r_vsync;
    logic [BASE_W-BASE_LSB-1:0] r_base;
    logic [31:0]              r_burst_cnt;
    logic                     r_pending;
    logic [AXI_ADDR_W-1:0]    r_araddr;
    logic [AXI_DATA_W-1:0]    r_wdata;
    logic                     r_wren;

    logic w_fs;
    logic w_beat;
    logic w_last;
    logic w_restart;
    logic w_relatch;
    logic w_issue;
    logic w_unused_addr_lsb;

    assign w_fs      = r_vsync & ~DSP_VSYNC_X;
    assign w_beat    = (r_state == S_DATA) & vram.RVALID;
    assign w_last    = w_beat & vram.RLAST;
    // A frame start seen while busy is only honoured at a burst boundary.
    assign w_restart = ((r_state == S_WAIT_BUF) & w_fs) | (w_last & (r_pending | w_fs));
    assign w_relatch = ((r_state == S_IDLE) & w_fs) | w_restart;
    assign w_issue   = (r_state == S_WAIT_BUF) & vram.BUF_WREADY & ~w_fs;

    assign w_unused_addr_lsb = ^DISPADDR[BASE_LSB-1:0];

    always_comb begin
        w_state_d = r_state;
        if (w_relatch) begin
            w_state_d = DISPON ? S_WAIT_BUF : S_IDLE;
        end else begin
            case (r_state)
                S_WAIT_BUF: if (vram.BUF_WREADY) w_state_d = S_ADDR;
                S_ADDR:     if (vram.ARREADY)    w_state_d = S_DATA;
                S_DATA: begin
                    if (w_last) begin
                        w_state_d = (r_burst_cnt == LAST_BURST) ? S_IDLE : S_WAIT_BUF;
                    end
                end
                default:    w_state_d = r_state;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARST_X) begin
        if (!ARST_X) begin
            r_state     <= S_IDLE;
            r_vsync     <= 1'b0;
            r_base      <= '0;
            r_burst_cnt <= '0;
            r_pending   <= 1'b0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_wren      <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_vsync <= DSP_VSYNC_X;

            if (w_relatch) begin
                r_base      <= DISPADDR[BASE_W-1:BASE_LSB];
                r_burst_cnt <= '0;
            end else if (w_last) begin
                r_burst_cnt <= r_burst_cnt + 32'd1;
            end

            if (w_restart) begin
                r_pending <= 1'b0;
            end else if (w_fs && (r_state == S_ADDR || r_state == S_DATA)) begin
                r_pending <= 1'b1;
            end

            if (w_issue) begin
                r_araddr <= {{(AXI_ADDR_W-BASE_W){1'b0}}, r_base, {BASE_LSB{1'b0}}}
                            + r_burst_cnt * BURST_BYTES;
            end

            r_wren <= w_beat;
            if (w_beat) r_wdata <= vram.RDATA;
        end
    end

    assign vram.ARADDR    = r_araddr;
    assign vram.ARLEN     = AXI_LEN_W'(BURST_LEN - 1);
    assign vram.ARVALID   = (r_state == S_ADDR);
    assign vram.RREADY    = (r_state == S_DATA);
    assign vram.BUF_WDATA = r_wdata;
    assign vram.BUF_WREN  = r_wren;

endmodule

// File: tb/tb_disp_vramctrl.sv
// Directed-plus-random bench for disp_vramctrl with an AXI slave and frame address model.
module tb_disp_vramctrl;

    localparam int unsigned H  = 64;
    localparam int unsigned V  = 32;
    localparam int unsigned BL = 16;
    localparam int unsigned NB = H * V / BL;
    localparam logic [31:0] BB = 32'(BL * 4);

    logic        ACLK = 1'b0;
    logic        ARST_X;
    logic        DSP_VSYNC_X;
    logic        DISPON;
    logic [28:0] DISPADDR;

    disp_vramctrl_if vram();

    disp_vramctrl #(.H_PIXELS(H), .V_LINES(V), .BURST_LEN(BL)) dut (
        .ACLK        (ACLK),
        .ARST_X      (ARST_X),
        .DSP_VSYNC_X (DSP_VSYNC_X),
        .DISPON      (DISPON),
        .DISPADDR    (DISPADDR),
        .vram        (vram)
    );

    always #5 ACLK = ~ACLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_base, pend_base, last_addr, hold_addr;
    int          exp_k, fr_ar, wren_cnt, beats_left, wren0;
    bit          pend, ar_mode, arvalid_seen, hold_valid;
    logic [31:0] wq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Mid-cycle observation: buffer writes, AR stability, address model, slave bookkeeping.
    task automatic monitor();
        if (!ARST_X) begin
            beats_left = 0;
            wq.delete();
            hold_valid = 0;
            return;
        end
        chk("rready", 32'(vram.RREADY), 32'(beats_left != 0));
        chk("buf_wren", 32'(vram.BUF_WREN), 32'(wq.size() != 0));
        if (wq.size() != 0) begin
            chk("buf_wdata", vram.BUF_WDATA, wq.pop_front());
            wren_cnt++;
        end
        if (hold_valid) begin
            chk("ar_hold_valid", 32'(vram.ARVALID), 32'd1);
            chk("ar_hold_addr", vram.ARADDR, hold_addr);
        end
        if (vram.RVALID && vram.RREADY) begin
            wq.push_back(vram.RDATA);
            beats_left--;
            if (vram.RLAST && pend) begin
                exp_base = pend_base;
                exp_k    = 0;
                fr_ar    = 0;
                pend     = 0;
            end
        end
        if (vram.ARVALID) arvalid_seen = 1;
        hold_valid = vram.ARVALID && !vram.ARREADY;
        hold_addr  = vram.ARADDR;
        if (vram.ARVALID && vram.ARREADY) begin
            chk("burst_in_frame", 32'(exp_k < int'(NB)), 32'd1);
            chk("araddr", vram.ARADDR, exp_base + 32'(exp_k) * BB);
            chk("arlen", 32'(vram.ARLEN), 32'(BL - 1));
            last_addr  = vram.ARADDR;
            exp_k++;
            fr_ar++;
            beats_left = BL;
        end
    endtask

    task automatic drive();
        if (!ARST_X) begin
            vram.ARREADY = 1'b0;
            vram.RVALID  = 1'b0;
            vram.RLAST   = 1'b0;
            return;
        end
        vram.ARREADY = ar_mode && ($urandom_range(0, 3) != 0);
        if (beats_left > 0 && $urandom_range(0, 3) != 0) begin
            vram.RVALID = 1'b1;
            vram.RDATA  = $urandom;
            vram.RLAST  = (beats_left == 1);
        end else begin
            vram.RVALID = 1'b0;
            vram.RLAST  = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
        monitor();
        @(posedge ACLK);
        #1;
        drive();
    endtask

    task automatic vsync_pulse();
        DSP_VSYNC_X = 1'b0;
        tick();
        tick();
        DSP_VSYNC_X = 1'b1;
    endtask

    task automatic new_frame(input logic [28:0] addr, input logic on);
        DISPADDR = addr;
        DISPON   = on;
        exp_base = 32'(addr) & ~32'h3F;
        exp_k    = 0;
        fr_ar    = 0;
    endtask

    task automatic wait_ar(input int n);
        for (int i = 0; i < 20000 && fr_ar < n; i++) tick();
        chk("reach_burst", 32'(fr_ar), 32'(n));
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 20000; i++) begin
            if (fr_ar == int'(NB) && beats_left == 0 && wq.size() == 0 && !pend) break;
            tick();
        end
        chk("frame_bursts", 32'(fr_ar), 32'(NB));
        arvalid_seen = 0;
        repeat (30) tick();
        chk("idle_after_frame", 32'(arvalid_seen), 32'd0);
    endtask

    initial begin
        ARST_X = 1'b0; DSP_VSYNC_X = 1'b1; DISPON = 1'b0; DISPADDR = '0;
        vram.BUF_WREADY = 1'b1; vram.ARREADY = 1'b0; vram.RVALID = 1'b0;
        vram.RLAST = 1'b0; vram.RDATA = '0;
        ar_mode = 0; pend = 0; wren_cnt = 0; beats_left = 0; hold_valid = 0;
        exp_base = '0; exp_k = 0; fr_ar = 0; last_addr = '0; pend_base = '0;
        repeat (3) tick();
        chk("rst_arvalid", 32'(vram.ARVALID), 32'd0);
        chk("rst_rready", 32'(vram.RREADY), 32'd0);
        chk("rst_wren", 32'(vram.BUF_WREN), 32'd0);
        chk("rst_araddr", vram.ARADDR, 32'd0);
        chk("rst_wdata", vram.BUF_WDATA, 32'd0);
        ARST_X = 1'b1;
        repeat (3) tick();

        // Frame start latency, first and second burst address, full frame accounting.
        new_frame(29'h0100_0000, 1'b1);
        wren0 = wren_cnt;
        DSP_VSYNC_X = 1'b0;
        tick();
        chk("arvalid_lat1", 32'(vram.ARVALID), 32'd0);
        tick();
        DSP_VSYNC_X = 1'b1;
        chk("arvalid_lat2", 32'(vram.ARVALID), 32'd1);
        chk("first_araddr", vram.ARADDR, 32'h0100_0000);
        chk("first_arlen", 32'(vram.ARLEN), 32'd15);
        repeat (3) tick();
        ar_mode = 1;
        wait_ar(2);
        chk("second_araddr", last_addr, 32'h0100_0040);
        wait_frame();
        chk("frame_wren", 32'(wren_cnt - wren0), 32'(NB * BL));
        chk("last_araddr", last_addr, 32'h0100_0000 + 32'(NB - 1) * BB);

        // Unaligned base, then buffer back-pressure between bursts.
        new_frame(29'h0000_0123, 1'b1);
        vsync_pulse();
        wait_ar(1);
        chk("masked_araddr", last_addr, 32'h0000_0100);
        vram.BUF_WREADY = 1'b0;
        for (int i = 0; i < 200 && (beats_left != 0 || wq.size() != 0); i++) tick();
        arvalid_seen = 0;
        repeat (50) tick();
        chk("no_ar_without_wready", 32'(arvalid_seen), 32'd0);
        vram.BUF_WREADY = 1'b1;
        for (int i = 0; i < 10 && !vram.ARVALID; i++) tick();
        chk("ar_after_wready", 32'(vram.ARVALID), 32'd1);
        chk("addr_after_wready", vram.ARADDR, 32'h0000_0140);
        wait_frame();

        // Display disabled at frame start.
        new_frame(29'h0200_0000, 1'b0);
        vsync_pulse();
        arvalid_seen = 0;
        repeat (300) tick();
        chk("dispon_off_no_ar", 32'(arvalid_seen), 32'd0);

        // Frame start inside burst 100: burst completes, restart at the new base.
        new_frame(29'h0200_0000, 1'b1);
        wren0 = wren_cnt;
        vsync_pulse();
        wait_ar(101);
        DISPADDR  = 29'h0300_0000;
        pend_base = 32'h0300_0000;
        pend      = 1;
        vsync_pulse();
        for (int i = 0; i < 200 && pend; i++) tick();
        chk("restart_seen", 32'(pend), 32'd0);
        wait_ar(1);
        chk("restart_araddr", last_addr, 32'h0300_0000);
        DISPON = 1'b0;
        wait_frame();
        chk("restart_wren", 32'(wren_cnt - wren0), 32'((101 + NB) * BL));
        chk("restart_last_addr", last_addr, 32'h0300_0000 + 32'(NB - 1) * BB);

        // Asynchronous reset while data beats are in flight.
        new_frame(29'h0400_0000, 1'b1);
        vsync_pulse();
        wait_ar(3);
        tick();
        tick();
        @(negedge ACLK);
        monitor();
        #2;
        ARST_X = 1'b0;
        #1;
        chk("arst_arvalid", 32'(vram.ARVALID), 32'd0);
        chk("arst_rready", 32'(vram.RREADY), 32'd0);
        chk("arst_wren", 32'(vram.BUF_WREN), 32'd0);
        chk("arst_araddr", vram.ARADDR, 32'd0);
        chk("arst_wdata", vram.BUF_WDATA, 32'd0);
        @(posedge ACLK);
        #1;
        drive();
        tick();
        tick();
        ARST_X = 1'b1;
        pend = 0;
        arvalid_seen = 0;
        repeat (30) tick();
        chk("idle_after_arst", 32'(arvalid_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
